// File: rtl/framelen_buf.sv
// framelen_buf
//   Frame buffer and length measurer for the UDP/IP transmit path.
//   Ingress AXI-Stream beats are stored in a first-word-fall-through data FIFO.
//   The valid bytes of each frame are counted from s_tkeep. LEN_OFFSET is added
//   to the count, and the result is pushed into a length FIFO when the tlast beat
//   is accepted. With STORE_FWD=1, a frame is held on the output until its last
//   beat has been buffered.
//
// Ports
//   clk, rst_n                    clock (rising edge), async active-low reset
//   s_tvalid/s_tready             ingress handshake
//   s_tdata, s_tkeep, s_tlast     ingress beat (keep contiguous from lane 0)
//   m_tvalid/m_tready             egress handshake
//   m_tdata, m_tkeep, m_tlast     buffered beat, unchanged
//   length_tvalid/length_tready   length handshake
//   length_tdata                  byte count + LEN_OFFSET, saturated at 0xFFFF
//   length_terr                   count > MAX_LEN, or the sum saturated
module framelen_buf #(
    parameter int unsigned DATA_BYTES = 1,
    parameter int unsigned DATA_DEPTH = 2048,
    parameter int unsigned LEN_DEPTH  = 16,
    parameter int unsigned LEN_OFFSET = 0,
    parameter int unsigned MAX_LEN    = 1500,
    parameter bit          STORE_FWD  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic [8*DATA_BYTES-1:0] s_tdata,
    input  logic [DATA_BYTES-1:0]   s_tkeep,
    input  logic                    s_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [8*DATA_BYTES-1:0] m_tdata,
    output logic [DATA_BYTES-1:0]   m_tkeep,
    output logic                    m_tlast,
    output logic                    length_tvalid,
    input  logic                    length_tready,
    output logic [15:0]             length_tdata,
    output logic                    length_terr
);

    localparam int unsigned DW  = 9*DATA_BYTES + 1;
    localparam int unsigned DAW = $clog2(DATA_DEPTH);
    localparam int unsigned LAW = $clog2(LEN_DEPTH);

    logic [DW-1:0] dmem [DATA_DEPTH];
    logic [16:0]   lmem [LEN_DEPTH];
    logic [DAW:0]  dwp, drp;
    logic [LAW:0]  lwp, lrp;
    logic [DAW:0]  complete_frames;
    logic [16:0]   acc;
    logic          rdy_en;

    logic          data_empty, data_full, len_empty, len_full;
    logic          wr, rd, len_wr, len_rd;
    logic [DW-1:0] rd_word;
    logic [16:0]   len_word;
    logic [3:0]    pc;
    logic [31:0]   bytes_tot, sum;
    logic [15:0]   len_sat;
    logic          len_err;
    logic [16:0]   acc_next;

    // The pointers carry one extra wrap bit. Equal low bits with differing
    // wrap bits means the FIFO is full.
    assign data_empty = (dwp == drp);
    assign data_full  = (dwp[DAW] != drp[DAW]) && (dwp[DAW-1:0] == drp[DAW-1:0]);
    assign len_empty  = (lwp == lrp);
    assign len_full   = (lwp[LAW] != lrp[LAW]) && (lwp[LAW-1:0] == lrp[LAW-1:0]);

    // rdy_en keeps s_tready low during reset and for the first edge after release.
    assign s_tready = rdy_en && !data_full && !len_full;
    assign wr       = s_tvalid && s_tready;
    assign len_wr   = wr && s_tlast;
    assign rd       = m_tvalid && m_tready;
    assign len_rd   = length_tvalid && length_tready;

    assign rd_word  = dmem[drp[DAW-1:0]];
    assign len_word = lmem[lrp[LAW-1:0]];

    // m_tvalid is built from registered state only. While the FIFO is full,
    // a frame larger than the FIFO drains cut-through instead of deadlocking.
    always_comb begin
        m_tvalid = !data_empty;
        if (STORE_FWD)
            m_tvalid = !data_empty && ((complete_frames != '0) || data_full);
    end

    // The outputs are gated with the empty flags, so they read zero after reset.
    assign m_tdata       = data_empty ? '0 : rd_word[DW-1 -: 8*DATA_BYTES];
    assign m_tkeep       = data_empty ? '0 : rd_word[DATA_BYTES:1];
    assign m_tlast       = !data_empty && rd_word[0];
    assign length_tvalid = !len_empty;
    assign length_tdata  = len_empty ? '0 : len_word[15:0];
    assign length_terr   = !len_empty && len_word[16];

    always_comb begin
        pc = '0;
        for (int unsigned i = 0; i < DATA_BYTES; i++)
            pc = pc + 4'(s_tkeep[i]);
    end

    always_comb begin
        bytes_tot = 32'(acc) + 32'(pc);
        sum       = bytes_tot + LEN_OFFSET;
        len_sat   = (sum > 32'h0000_FFFF) ? 16'hFFFF : sum[15:0];
        len_err   = (bytes_tot > MAX_LEN) || (sum > 32'h0000_FFFF);
        acc_next  = (bytes_tot > 32'h0001_FFFF) ? '1 : bytes_tot[16:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en          <= 1'b0;
            dwp             <= '0;
            drp             <= '0;
            lwp             <= '0;
            lrp             <= '0;
            acc             <= '0;
            complete_frames <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (wr)     dwp <= dwp + 1'b1;
            if (rd)     drp <= drp + 1'b1;
            if (len_wr) lwp <= lwp + 1'b1;
            if (len_rd) lrp <= lrp + 1'b1;
            if (wr)     acc <= s_tlast ? '0 : acc_next;
            case ({len_wr, rd && rd_word[0]})
                2'b10:   complete_frames <= complete_frames + 1'b1;
                2'b01:   complete_frames <= complete_frames - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr)     dmem[dwp[DAW-1:0]] <= {s_tdata, s_tkeep, s_tlast};
        if (len_wr) lmem[lwp[LAW-1:0]] <= {len_err, len_sat};
    end

endmodule

// File: tb/tb_framelen_buf.sv
// Testbench for framelen_buf: a scoreboard with directed frames.
// DUT configuration: 4 lanes, DATA_DEPTH=16, LEN_DEPTH=4, LEN_OFFSET=28,
// MAX_LEN=100, store-and-forward mode.
module tb_framelen_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_tvalid, s_tready, s_tlast;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        m_tvalid, m_tready, m_tlast;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        length_tvalid, length_tready, length_terr;
    logic [15:0] length_tdata;

    always #5 clk = ~clk;

    framelen_buf #(
        .DATA_BYTES(4), .DATA_DEPTH(16), .LEN_DEPTH(4),
        .LEN_OFFSET(28), .MAX_LEN(100), .STORE_FWD(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .length_tvalid(length_tvalid), .length_tready(length_tready),
        .length_tdata(length_tdata), .length_terr(length_terr)
    );

    logic [36:0] dq[$];   // {tdata, tkeep, tlast}
    logic [16:0] lq[$];   // {err, length}
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: on every output handshake, pop the oldest expected entry and compare.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_tvalid && m_tready) begin
                if (dq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL m_beat_unexpected: got data %0h expected none", m_tdata);
                end else begin
                    logic [36:0] e;
                    e = dq.pop_front();
                    check("m_tdata", 64'(m_tdata), 64'(e[36:5]));
                    check("m_tkeep", 64'(m_tkeep), 64'(e[4:1]));
                    check("m_tlast", 64'(m_tlast), 64'(e[0]));
                end
            end
            if (length_tvalid && length_tready) begin
                if (lq.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL length_unexpected: got %0d expected none", length_tdata);
                end else begin
                    logic [16:0] e;
                    e = lq.pop_front();
                    check("length_tdata", 64'(length_tdata), 64'(e[15:0]));
                    check("length_terr", 64'(length_terr), 64'(e[16]));
                end
            end
        end
    end

    // Drives one beat. Call this just after a posedge; it returns just after the accepting posedge.
    task automatic send(input logic [3:0] keep, input logic last, input logic [16:0] exp_len);
        logic [31:0] d;
        int n;
        d = $urandom();
        n = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tkeep = keep; s_tlast = last;
        @(negedge clk);
        while (!s_tready && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (!s_tready) begin
            vectors++; miscompares++;
            $display("FAIL s_tready_timeout: got 0 expected 1");
        end else begin
            dq.push_back({d, keep, last});
            if (last) lq.push_back(exp_len);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic send_full_beats(input int n);
        for (int i = 0; i < n; i++) send(4'hF, 1'b0, 17'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((dq.size() != 0 || lq.size() != 0) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_data_q", 64'(dq.size()), 64'd0);
        check("drain_len_q", 64'(lq.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        m_tready = 1'b1; length_tready = 1'b1;
        #2;
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_length_tvalid", 64'(length_tvalid), 64'd0);
        check("rst_m_tlast", 64'(m_tlast), 64'd0);
        check("rst_length_tdata", 64'(length_tdata), 64'd0);
        check("rst_length_terr", 64'(length_terr), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 check("s_tready_before_first_edge", 64'(s_tready), 64'd0);
        @(negedge clk);
        check("s_tready_after_first_edge", 64'(s_tready), 64'd1);
        @(posedge clk); #1;

        // 1-byte frame -> 1 + 28 = 29; output appears the cycle after tlast
        check("m_tvalid_before_tlast", 64'(m_tvalid), 64'd0);
        send(4'h1, 1'b1, {1'b0, 16'd29});
        check("m_tvalid_after_tlast", 64'(m_tvalid), 64'd1);
        check("length_tvalid_after_tlast", 64'(length_tvalid), 64'd1);
        drain();

        // 10-byte frame with keeps F,F,3 -> 38; the frame is held until tlast
        send(4'hF, 1'b0, 17'd0);
        send(4'hF, 1'b0, 17'd0);
        check("m_tvalid_held_sf", 64'(m_tvalid), 64'd0);
        send(4'h3, 1'b1, {1'b0, 16'd38});
        check("m_tvalid_release_sf", 64'(m_tvalid), 64'd1);
        drain();

        // A zero-keep beat is forwarded but adds no bytes: F,0,3 -> 6 + 28 = 34
        send(4'hF, 1'b0, 17'd0);
        send(4'h0, 1'b0, 17'd0);
        send(4'h3, 1'b1, {1'b0, 16'd34});
        drain();

        // 20-beat frame in a 16-deep FIFO: escape release at full; 80 + 28 = 108
        send_full_beats(19);
        send(4'hF, 1'b1, {1'b0, 16'd108});
        drain();

        // 101 bytes > MAX_LEN -> err=1, 129; exactly 100 bytes -> err=0, 128
        send_full_beats(25);
        send(4'h1, 1'b1, {1'b1, 16'd129});
        drain();
        send_full_beats(24);
        send(4'hF, 1'b1, {1'b0, 16'd128});
        drain();

        // Back-pressure: a full length FIFO drops s_tready; lengths pop in order
        m_tready = 1'b0; length_tready = 1'b0;
        send(4'h1, 1'b1, {1'b0, 16'd29});
        send(4'h3, 1'b1, {1'b0, 16'd30});
        send(4'h7, 1'b1, {1'b0, 16'd31});
        send(4'hF, 1'b1, {1'b0, 16'd32});
        check("s_tready_len_full", 64'(s_tready), 64'd0);
        check("length_tvalid_held", 64'(length_tvalid), 64'd1);
        repeat (3) @(posedge clk);
        #1 check("s_tready_stays_low", 64'(s_tready), 64'd0);
        m_tready = 1'b1; length_tready = 1'b1;
        send(4'h3, 1'b1, {1'b0, 16'd30});
        drain();

        // Reset mid-frame after 5 beats; the partial frame and its count are discarded
        send_full_beats(5);
        check("m_tvalid_partial_held", 64'(m_tvalid), 64'd0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        dq.delete();
        lq.delete();
        check("midrst_s_tready", 64'(s_tready), 64'd0);
        check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("midrst_length_tvalid", 64'(length_tvalid), 64'd0);
        check("midrst_m_tlast", 64'(m_tlast), 64'd0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_m_tvalid_hold", 64'(m_tvalid), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("s_tready_after_midrst", 64'(s_tready), 64'd1);
        send(4'h7, 1'b1, {1'b0, 16'd31});
        drain();
        repeat (3) @(posedge clk);
        #1 check("no_extra_length", 64'(length_tvalid), 64'd0);
        check("no_extra_data", 64'(m_tvalid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/framelen_buf.md
# framelen_buf

Parametrised frame buffer and length measurer for the UDP/IP transmit path, successor to the single-byte length counter. It accepts an AXI-Stream frame of `DATA_BYTES` lanes and buffers it in an internal FIFO. It counts valid bytes per frame from `s_tkeep`, adds a fixed header offset, and pushes the result into a length FIFO. The IP header builder pops the length before it consumes the frame. An optional store-and-forward mode holds each frame on the output until its length is known.

## Interface
- `DATA_BYTES`, 1 — lanes per beat (1..8); data width = 8*DATA_BYTES.
- `DATA_DEPTH`, 2048 — data FIFO depth in beats (power of 2).
- `LEN_DEPTH`, 16 — length FIFO depth in entries (power of 2).
- `LEN_OFFSET`, 0 — constant added to each byte count (e.g. 28 for IP+UDP headers).
- `MAX_LEN`, 1500 — byte count above which a frame is flagged oversize.
- `STORE_FWD`, 1 — 1: release a frame only after its last beat is buffered; 0: cut-through.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_tvalid`/`s_tready`  in/out  1  ingress handshake.
- `s_tdata`  in  8*DATA_BYTES  ingress data.
- `s_tkeep`  in  DATA_BYTES  byte-valid mask, contiguous from lane 0.
- `s_tlast`  in  1  final beat of frame.
- `m_tvalid`/`m_tready`  out/in  1  egress handshake.
- `m_tdata`, `m_tkeep`, `m_tlast`  out  as ingress  buffered beat, unchanged.
- `length_tvalid`/`length_tready`  out/in  1  length handshake.
- `length_tdata`  out  16  byte count + LEN_OFFSET, saturated at 0xFFFF.
- `length_terr`  out  1  frame byte count > MAX_LEN, or the sum saturated.

## Operation
- Data FIFO: first-word-fall-through storage of {tdata, tkeep, tlast}; write on s_tvalid&s_tready, read on m_tvalid&m_tready.
- `s_tready = !data_full && !len_full`. A tlast beat therefore always finds room in the length FIFO (fixes the old unchecked length-FIFO overflow).
- Byte accumulator, 17 bits: on each accepted beat add popcount(s_tkeep).
  - On a tlast beat, push {err, sat(acc + popcount + LEN_OFFSET)} and clear the accumulator to 0.
  - The count includes the last beat; a 1-byte frame yields 1 + LEN_OFFSET.
  - Saturation: result ≥ 0x10000 → 0xFFFF with err=1.
- `complete_frames` counter, width clog2(DATA_DEPTH)+1:
  - +1 on tlast write, −1 on tlast read, unchanged when both occur in the same cycle.
- m_tvalid:
  - STORE_FWD=0: `!data_empty`.
  - STORE_FWD=1: `!data_empty && (complete_frames != 0 || data_full)`.
  - The data_full term is the escape path: a frame larger than the FIFO drains cut-through, and m_tvalid may toggle while it does. This guarantees no deadlock.
- `length_tvalid = !len_empty`; length entries pop independently of data.
- s_tkeep == 0 on a beat adds 0 bytes; the beat is still stored and forwarded.

## Timing
- Reset (`rst_n` low, asynchronous):
  - FIFO pointers, accumulator and complete_frames cleared.
  - s_tready = 0 while in reset; m_tvalid = 0; length_tvalid = 0; m_tlast = 0; length_tdata = 0; length_terr = 0.
  - s_tready rises on the first clk edge after release.
- Reset mid-frame: all buffered data and any partial count are discarded; the next accepted beat starts a new frame.
- Data latency:
  - Cut-through: beat accepted at edge N → visible on m_* after edge N (next cycle).
  - Store-and-forward: first beat visible the cycle after the tlast beat is accepted.
- Length latency: length_tvalid asserts the cycle after the tlast beat is accepted.
- Full throughput: one beat in and one beat out per cycle, sustained with no bubbles.
- Full boundary: at data_full, a simultaneous read does not reopen s_tready in the same cycle; s_tready is registered-full based.
- Empty boundary: no combinational path from s_tvalid to m_tvalid.

## Test plan
- DATA_BYTES=1, LEN_OFFSET=28: 1-byte frame, then 64-byte frame → lengths 29, 92; m_tvalid rises the cycle after each tlast.
- DATA_BYTES=4: 10-byte frame (beats keep F,F,3) → length 10; m_tkeep sequence F,F,3 reproduced exactly.
- Back-to-back frames, m_tready and length_tready held low until LEN_DEPTH lengths are stored → s_tready drops; no entry lost; all lengths pop in order.
- STORE_FWD=1, DATA_DEPTH=16, 20-beat frame → escape release at full, all 20 beats delivered, length 20.
- MAX_LEN=100, 101-byte frame → length_terr=1; 100-byte frame → length_terr=0.
- rst_n asserted mid-frame after 5 beats, then a 3-byte frame → single length 3; m_tvalid=0 throughout reset.
